// File: rtl/mac_result_collector.sv
// Realigns super_MAC flags, accumulates channel-group passes, rescales/saturates and queues results.
// Result appears MAC_LATENCY+1 cycles after the last issue; upstream is throttled by a combinational credit.
module mac_result_collector #(
    parameter int ACCUMULATOR_WIDTH = 32,
    parameter int OUTPUT_WIDTH      = 16,
    parameter int OUT_SCALE         = 8,
    parameter int MAC_LATENCY       = 2,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                clk,
    input  logic                                arst_n_in,
    input  logic                                issue_valid_in,
    input  logic                                issue_first_in,
    input  logic                                issue_last_in,
    input  logic signed [ACCUMULATOR_WIDTH-1:0] mac_in,
    output logic                                issue_ready_out,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic        [OUTPUT_WIDTH-1:0]      out_data,
    output logic                                sat_flag,
    output logic                                err_flag
);

    localparam int AW     = ACCUMULATOR_WIDTH;
    localparam int OW     = OUTPUT_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PEND_W = $clog2(FIFO_DEPTH + MAC_LATENCY + 1);

    localparam logic signed [AW:0]   ACC_MAX = {2'b00, {(AW-1){1'b1}}};
    localparam logic signed [AW:0]   ACC_MIN = {2'b11, {(AW-1){1'b0}}};
    localparam logic signed [AW-1:0] OUT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] OUT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic [MAC_LATENCY-1:0] r_dv;
    logic [MAC_LATENCY-1:0] r_df;
    logic [MAC_LATENCY-1:0] r_dl;
    logic signed [AW-1:0]   r_acc;
    logic [OW-1:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_sat;
    logic                   r_err;

    logic                   w_d_valid;
    logic                   w_d_first;
    logic                   w_d_last;
    logic signed [AW:0]     w_sum;
    logic                   w_acc_hi;
    logic                   w_acc_lo;
    logic signed [AW-1:0]   w_acc_clamped;
    logic signed [AW-1:0]   w_acc_next;
    logic signed [AW-1:0]   w_shifted;
    logic                   w_res_hi;
    logic                   w_res_lo;
    logic [OW-1:0]          w_res;
    logic                   w_push_req;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_drop;
    logic                   w_push;
    logic                   w_acc_sat;
    logic                   w_res_sat;
    logic [PEND_W-1:0]      w_pending;

    assign w_d_valid = r_dv[MAC_LATENCY-1];
    assign w_d_first = r_df[MAC_LATENCY-1];
    assign w_d_last  = r_dl[MAC_LATENCY-1];

    // One guard bit is enough to detect overflow of a two-operand signed add.
    assign w_sum         = {mac_in[AW-1], mac_in} + {r_acc[AW-1], r_acc};
    assign w_acc_hi      = w_sum > ACC_MAX;
    assign w_acc_lo      = w_sum < ACC_MIN;
    assign w_acc_clamped = w_acc_hi ? ACC_MAX[AW-1:0] :
                           w_acc_lo ? ACC_MIN[AW-1:0] : w_sum[AW-1:0];
    assign w_acc_next    = w_d_first ? mac_in : w_acc_clamped;

    assign w_shifted = w_acc_next >>> OUT_SCALE;
    assign w_res_hi  = w_shifted > OUT_MAX;
    assign w_res_lo  = w_shifted < OUT_MIN;
    assign w_res     = w_res_hi ? OUT_MAX[OW-1:0] :
                       w_res_lo ? OUT_MIN[OW-1:0] : w_shifted[OW-1:0];

    assign w_push_req = w_d_valid & w_d_last;
    assign w_pop      = out_valid & out_ready;
    assign w_full     = r_count == CNT_W'(FIFO_DEPTH);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_push     = w_push_req & ~w_drop;
    assign w_acc_sat  = w_d_valid & ~w_d_first & (w_acc_hi | w_acc_lo);
    assign w_res_sat  = w_push_req & (w_res_hi | w_res_lo);

    // Results still inside the MAC pipeline already own a FIFO slot.
    always_comb begin
        w_pending = PEND_W'(r_count);
        for (int i = 0; i < MAC_LATENCY; i++) begin
            w_pending = w_pending + PEND_W'(r_dl[i]);
        end
    end

    assign issue_ready_out = w_pending < PEND_W'(FIFO_DEPTH);
    assign out_valid       = r_count != '0;
    assign out_data        = out_valid ? r_mem[r_rd_ptr] : '0;
    assign sat_flag        = r_sat;
    assign err_flag        = r_err;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_dv <= '0;
            r_df <= '0;
            r_dl <= '0;
        end else begin
            r_dv[0] <= issue_valid_in;
            r_df[0] <= issue_valid_in & issue_first_in;
            r_dl[0] <= issue_valid_in & issue_last_in;
            for (int i = 1; i < MAC_LATENCY; i++) begin
                r_dv[i] <= r_dv[i-1];
                r_df[i] <= r_df[i-1];
                r_dl[i] <= r_dl[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_acc <= '0;
        end else if (w_d_valid) begin
            r_acc <= w_acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_res;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_sat <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_sat <= r_sat | w_acc_sat | w_res_sat;
            r_err <= r_err | w_drop;
        end
    end

endmodule

// File: tb/tb_mac_result_collector.sv
// Bench for mac_result_collector: directed scenarios then random pixels against a queue-based reference.
module tb_mac_result_collector;
    localparam int AW    = 32;
    localparam int OW    = 16;
    localparam int SH    = 8;
    localparam int ML    = 2;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 arst_n_in;
    logic                 issue_valid_in;
    logic                 issue_first_in;
    logic                 issue_last_in;
    logic signed [AW-1:0] mac_in;
    logic                 issue_ready_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [OW-1:0]        out_data;
    logic                 sat_flag;
    logic                 err_flag;

    always #5 clk = ~clk;

    mac_result_collector #(
        .ACCUMULATOR_WIDTH(AW), .OUTPUT_WIDTH(OW), .OUT_SCALE(SH),
        .MAC_LATENCY(ML), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in),
        .issue_valid_in(issue_valid_in), .issue_first_in(issue_first_in),
        .issue_last_in(issue_last_in), .mac_in(mac_in),
        .issue_ready_out(issue_ready_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .sat_flag(sat_flag), .err_flag(err_flag)
    );

    typedef struct {
        int         due;
        bit         last;
        logic [15:0] res;
        bit         sat;
    } item_t;

    item_t       inflight[$];
    logic [15:0] mq[$];
    longint      macc;
    bit          exp_sat;
    bit          exp_err;
    int          cyc;
    int          n_vec;
    int          n_err;
    int          m0;
    int          m1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int pend;
        pend = mq.size();
        foreach (inflight[i]) if (inflight[i].last) pend++;
        chk("out_valid", out_valid, mq.size() != 0);
        chk("out_data", out_data, (mq.size() != 0) ? mq[0] : 16'h0);
        chk("issue_ready", issue_ready_out, pend < DEPTH);
        chk("sat_flag", sat_flag, exp_sat);
        chk("err_flag", err_flag, exp_err);
    endtask

    // Reference: pixel value computed with wide integer arithmetic when the pass is issued.
    task automatic model_issue();
        item_t  it;
        longint s;
        longint r;
        it.sat  = 0;
        it.last = issue_last_in;
        it.due  = cyc + ML;
        it.res  = 16'h0;
        if (issue_first_in) begin
            macc = longint'(m0);
        end else begin
            s = macc + longint'(m0);
            if (s > 64'sd2147483647) begin s = 64'sd2147483647; it.sat = 1; end
            if (s < -64'sd2147483648) begin s = -64'sd2147483648; it.sat = 1; end
            macc = s;
        end
        if (issue_last_in) begin
            r = macc >>> SH;
            if (r > 32767) begin r = 32767; it.sat = 1; end
            if (r < -32768) begin r = -32768; it.sat = 1; end
            it.res = 16'(r);
        end
        inflight.push_back(it);
    endtask

    task automatic tick();
        bit    pop;
        int    sz;
        item_t it;
        pop = (mq.size() != 0) && (out_ready === 1'b1);
        sz  = mq.size();
        @(posedge clk);
        cyc++;
        if (pop) void'(mq.pop_front());
        while (inflight.size() != 0 && inflight[0].due == cyc) begin
            it = inflight.pop_front();
            if (it.sat) exp_sat = 1;
            if (it.last) begin
                if (sz == DEPTH && !pop) exp_err = 1;
                else mq.push_back(it.res);
            end
        end
        if (issue_valid_in) model_issue();
        #1;
        mac_in = m1;
        m1     = m0;
        m0     = 0;
        check_outputs();
    endtask

    task automatic pass(input bit f, input bit l, input int mac);
        issue_valid_in = 1'b1;
        issue_first_in = f;
        issue_last_in  = l;
        m0 = mac;
        tick();
        issue_valid_in = 1'b0;
        issue_first_in = 1'b0;
        issue_last_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        #2;
        arst_n_in      = 1'b0;
        issue_valid_in = 1'b0;
        issue_first_in = 1'b0;
        issue_last_in  = 1'b0;
        mac_in = 0; m0 = 0; m1 = 0;
        mq.delete();
        inflight.delete();
        macc = 0; exp_sat = 0; exp_err = 0;
        #1;
        check_outputs();
        @(posedge clk);
        #3;
        arst_n_in = 1'b1;
    endtask

    function automatic int rand_mac();
        if ($urandom_range(0, 7) == 0) return int'($urandom);
        return int'($urandom_range(0, 2097152)) - 1048576;
    endfunction

    initial begin
        int np;
        int w;
        n_vec = 0; n_err = 0; cyc = 0;
        m0 = 0; m1 = 0; macc = 0; exp_sat = 0; exp_err = 0;
        arst_n_in = 1'b0;
        issue_valid_in = 1'b0; issue_first_in = 1'b0; issue_last_in = 1'b0;
        mac_in = 0; out_ready = 1'b1;
        #1;
        check_outputs();
        #19;
        arst_n_in = 1'b1;

        // Single pass: result three cycles after issue.
        out_ready = 1'b1;
        pass(1, 1, 32'h0000_1200);
        idle(1);
        chk("t1_early", out_valid, 1'b0);
        idle(1);
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_data", out_data, 16'h0012);
        idle(2);

        // Three-pass pixel held in the FIFO.
        out_ready = 1'b0;
        pass(1, 0, 1000 * 256);
        pass(0, 0, -300 * 256);
        pass(0, 1, 56 * 256);
        idle(3);
        chk("t2_data", out_data, 16'd756);
        out_ready = 1'b1;
        idle(1);
        chk("t2_single", out_valid, 1'b0);

        // Output saturation, then accumulator saturation from a clean state.
        out_ready = 1'b0;
        pass(1, 1, 32'h7FFF_FFFF);
        idle(2);
        chk("t3_outsat", out_data, 16'h7FFF);
        chk("t3_satflag", sat_flag, 1'b1);
        do_reset();
        out_ready = 1'b0;
        pass(1, 0, 32'h7FFF_FF00);
        pass(0, 1, 32'h0000_1000);
        idle(3);
        chk("t3_accsat", out_data, 16'h7FFF);
        chk("t3_accflag", sat_flag, 1'b1);
        out_ready = 1'b1;
        idle(2);

        // Backpressure and credit.
        out_ready = 1'b0;
        pass(1, 1, 32'h100);
        pass(1, 1, 32'h200);
        pass(1, 1, 32'h300);
        pass(1, 1, 32'h400);
        chk("t4_nocredit", issue_ready_out, 1'b0);
        idle(4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_credit", issue_ready_out, 1'b1);
        chk("t4_order", out_data, 16'h0002);

        // Full FIFO: push coinciding with pop, then a forced drop.
        pass(1, 1, 32'h500);
        idle(3);
        chk("t5_full", issue_ready_out, 1'b0);
        pass(1, 1, 32'h600);
        idle(1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_noerr", err_flag, 1'b0);
        chk("t5_head", out_data, 16'h0003);
        pass(1, 1, 32'h700);
        idle(2);
        chk("t5_err", err_flag, 1'b1);
        out_ready = 1'b1;
        idle(6);

        // Reset in the middle of a pixel with a result waiting.
        out_ready = 1'b0;
        pass(1, 1, 32'h800);
        idle(3);
        pass(1, 0, 32'h1234_5600);
        pass(0, 0, 32'h0011_2200);
        do_reset();
        chk("t6_cleared", out_valid, 1'b0);
        pass(1, 1, 32'h100);
        idle(2);
        chk("t6_fresh", out_data, 16'h0001);
        out_ready = 1'b1;
        idle(2);

        // Random pixels under random backpressure, always honouring credit.
        for (int px = 0; px < 200; px++) begin
            np = $urandom_range(1, 4);
            for (int p = 0; p < np; p++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (p == np - 1) begin
                    w = 0;
                    while (issue_ready_out !== 1'b1 && w < 64) begin
                        out_ready = ($urandom_range(0, 3) != 0);
                        tick();
                        w++;
                    end
                    if (w == 64) chk("credit_timeout", issue_ready_out, 1'b1);
                end
                pass(p == 0, p == np - 1, rand_mac());
            end
            out_ready = ($urandom_range(0, 3) != 0);
            idle($urandom_range(0, 2));
        end

        out_ready = 1'b1;
        idle(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
